// File: rtl/biquad_iir_engine_if.sv
// Purpose : sample strobe/result bus plus coefficient-mux select/return for biquad_iir_engine.
// Latency : none (wires only); coef_in must answer coef_sel combinationally.
// Backpr. : none; start is a strobe, dropped by the engine while busy.
interface biquad_iir_engine_if #(
  parameter int N = 25
);
  logic         start;
  logic [N-1:0] x_in;
  logic [2:0]   coef_sel;
  logic [N-1:0] coef_in;
  logic [N-1:0] y_out;
  logic         done;
  logic         busy;

  // Sample source + coefficient mux side
  modport master (
    output start,
    output x_in,
    input  coef_sel,
    output coef_in,
    input  y_out,
    input  done,
    input  busy
  );

  // Engine side
  modport slave (
    input  start,
    input  x_in,
    output coef_sel,
    input  coef_in,
    output y_out,
    output done,
    output busy
  );
endinterface

// File: rtl/biquad_iir_engine.sv
// Purpose : sequential single-MAC Direct-Form-I biquad, y = b0x0+b1x1+b2x2-a1y1-a2y2, signed Q4.20 default.
// Latency : start at edge k -> y_out/done after edge k+6; one sample per 7 cycles back-to-back.
// Backpr. : start while busy is ignored (no queueing). Macro BIQUAD_SAT_EN: saturate result, else wrap.
module biquad_iir_engine #(
  parameter int N    = 25,
  parameter int FRAC = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  biquad_iir_engine_if.slave bus
);

  localparam int PW = 2 * N;
  localparam int AW = 2 * N + 3;

  localparam logic [2:0] SEL_A1   = 3'b000;
  localparam logic [2:0] SEL_A2   = 3'b001;
  localparam logic [2:0] SEL_B0   = 3'b010;
  localparam logic [2:0] SEL_B1   = 3'b011;
  localparam logic [2:0] SEL_B2   = 3'b100;
  localparam logic [2:0] SEL_NONE = 3'b101;

  // Half an output LSB, added before the arithmetic shift for round-half-up.
  localparam logic signed [AW-1:0] RND = {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_B0   = 3'd1,
    S_B1   = 3'd2,
    S_B2   = 3'd3,
    S_A1   = 3'd4,
    S_A2   = 3'd5,
    S_OUT  = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic signed [N-1:0]  r_x0;
  logic signed [N-1:0]  r_x1;
  logic signed [N-1:0]  r_x2;
  logic signed [N-1:0]  r_y1;
  logic signed [N-1:0]  r_y2;
  logic signed [AW-1:0] r_acc;
  logic signed [N-1:0]  r_y_out;
  logic                 r_done;

  logic [2:0]           w_coef_sel;
  logic signed [N-1:0]  w_operand;
  logic                 w_sub;
  logic                 w_mac_en;
  logic signed [PW-1:0] w_coef_ext;
  logic signed [PW-1:0] w_op_ext;
  logic signed [PW-1:0] w_prod;
  logic signed [AW-1:0] w_prod_ext;
  logic signed [AW-1:0] w_acc_next;
  logic signed [AW-1:0] w_rnd;
  logic signed [AW-1:0] w_shift;
  logic signed [N-1:0]  w_result;

  // State register; reset aborts any computation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: fixed walk B0..A2 then OUT; only IDLE looks at start.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_B0;
      S_B0:    w_next = S_B1;
      S_B1:    w_next = S_B2;
      S_B2:    w_next = S_A1;
      S_A1:    w_next = S_A2;
      S_A2:    w_next = S_OUT;
      S_OUT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Per-state coefficient select, matching operand and add/subtract choice.
  always_comb begin
    w_coef_sel = SEL_NONE;
    w_operand  = '0;
    w_sub      = 1'b0;
    w_mac_en   = 1'b0;
    case (r_state)
      S_B0: begin
        w_coef_sel = SEL_B0;
        w_operand  = r_x0;
        w_mac_en   = 1'b1;
      end
      S_B1: begin
        w_coef_sel = SEL_B1;
        w_operand  = r_x1;
        w_mac_en   = 1'b1;
      end
      S_B2: begin
        w_coef_sel = SEL_B2;
        w_operand  = r_x2;
        w_mac_en   = 1'b1;
      end
      S_A1: begin
        w_coef_sel = SEL_A1;
        w_operand  = r_y1;
        w_sub      = 1'b1;
        w_mac_en   = 1'b1;
      end
      S_A2: begin
        w_coef_sel = SEL_A2;
        w_operand  = r_y2;
        w_sub      = 1'b1;
        w_mac_en   = 1'b1;
      end
      default: begin
        w_coef_sel = SEL_NONE;
      end
    endcase
  end

  // Full-precision product; both operands widened so the multiply is 2N x 2N -> 2N.
  assign w_coef_ext = {{N{bus.coef_in[N-1]}}, bus.coef_in};
  assign w_op_ext   = {{N{w_operand[N-1]}}, w_operand};
  assign w_prod     = w_coef_ext * w_op_ext;
  assign w_prod_ext = {{(AW-PW){w_prod[PW-1]}}, w_prod};
  assign w_acc_next = w_sub ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);

  // Round half up, then drop the coefficient fraction bits.
  assign w_rnd   = r_acc + RND;
  assign w_shift = w_rnd >>> FRAC;

`ifdef BIQUAD_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};

  // Clamp the rounded sum to the N-bit signed range.
  always_comb begin
    w_result = w_shift[N-1:0];
    if (w_shift > SAT_MAX) begin
      w_result = SAT_MAX[N-1:0];
    end else if (w_shift < SAT_MIN) begin
      w_result = SAT_MIN[N-1:0];
    end
  end
`else
  logic w_unused_shift_hi;

  // Two's-complement wrap: keep the low N bits only.
  assign w_result          = w_shift[N-1:0];
  assign w_unused_shift_hi = ^w_shift[AW-1:N];
`endif

  // Accumulator: cleared on accepted start, one MAC term per B/A state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_acc <= '0;
    end else if (w_mac_en) begin
      r_acc <= w_acc_next;
    end
  end

  // Sample history: x0 latched on start, whole delay line shifts once in OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x0 <= '0;
      r_x1 <= '0;
      r_x2 <= '0;
      r_y1 <= '0;
      r_y2 <= '0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_x0 <= bus.x_in;
    end else if (r_state == S_OUT) begin
      r_x2 <= r_x1;
      r_x1 <= r_x0;
      r_y2 <= r_y1;
      r_y1 <= w_result;
    end
  end

  // Output register and single-cycle done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_out <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == S_OUT);
      if (r_state == S_OUT) begin
        r_y_out <= w_result;
      end
    end
  end

  assign bus.coef_sel = w_coef_sel;
  assign bus.y_out    = r_y_out;
  assign bus.done     = r_done;
  assign bus.busy     = (r_state != S_IDLE);

endmodule
